// File: rtl/mem_pkg.sv
// ----------------------------------------------------------------------------
// mem_pkg: shared constants and types for the block-transfer memory arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_pkg;

  localparam int WORD_W          = 32;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int BEAT_W          = 3;
  localparam int BLOCK_OFFSET_W  = BEAT_W + 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    BEAT     = 2'd2,
    DONE     = 2'd3
  } arb_state_t;

  typedef logic port_id_t;

  // Clears the byte-within-block offset so memory always sees the block base.
  function automatic logic [WORD_W-1:0] block_base(input logic [WORD_W-1:0] addr,
                                                   input int                off_w);
    return addr & ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2: two-input round-robin grant; LAST pointer resets to port 1.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_arbiter2
  import mem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_valid_o,
  output port_id_t   gnt_port_o
);

  port_id_t last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else if (advance_i && gnt_valid_o) begin
      last_q <= gnt_port_o;
    end
  end

  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_port_o = ~last_q;
    end else begin
      gnt_port_o = req_i[1];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_block_arbiter.sv
// ----------------------------------------------------------------------------
// mem_block_arbiter: shares one block-transfer memory port between I/D caches.
// Optional stall timeout: define MEM_ARB_TIMEOUT_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_block_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int BEAT_W          = 3,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [31:0]       addr0_i,
  input  logic [31:0]       addr1_i,
  input  logic [31:0]       wdata0_i,
  input  logic [31:0]       wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic [BEAT_W-1:0] beat_idx_o,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              mem_valid_o,
  output logic              mem_load_o,
  output logic              mem_store_o,
  output logic [31:0]       mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ready_i,
  input  logic              mem_beat_valid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              err_o
);

  import mem_pkg::*;

  if (TIMEOUT_CYCLES < 2 || WORDS_PER_BLOCK < 2 || (1 << BEAT_W) != WORDS_PER_BLOCK) begin : g_bad_cfg
    $error("mem_block_arbiter: inconsistent WORDS_PER_BLOCK/BEAT_W/TIMEOUT_CYCLES");
  end

  arb_state_t        state_q, state_d;
  port_id_t          port_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;

  logic              w_gnt_valid;
  port_id_t          w_gnt_port;
  logic              w_take;
  logic              w_beat_last;
  logic              w_timeout;
  logic              w_xfer;

  assign w_take      = (state_q == IDLE) && w_gnt_valid;
  assign w_beat_last = (beat_q == BEAT_W'(WORDS_PER_BLOCK - 1));

  rr_arbiter2 u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       ({req1_i, req0_i}),
    .advance_i   (w_take),
    .gnt_valid_o (w_gnt_valid),
    .gnt_port_o  (w_gnt_port)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [STALL_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = '0;
    if ((state_q == BEAT) && mem_beat_valid_i) begin
      stall_d = '0;
    end else if ((state_q == WAIT_RDY) || (state_q == BEAT)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  // >= so a stall that crosses the limit during the WAIT_RDY->BEAT hop still fires.
  assign w_timeout = (int'(stall_q) >= TIMEOUT_CYCLES - 1);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      if (w_take) begin
        port_q <= w_gnt_port;
        we_q   <= w_gnt_port ? we1_i : we0_i;
        addr_q <= block_base(w_gnt_port ? addr1_i : addr0_i, BEAT_W + 2);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        err_d  = 1'b0;
        beat_d = '0;
        if (w_gnt_valid) begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (mem_ready_i) begin
          state_d = BEAT;
        end else if (w_timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      BEAT: begin
        if (mem_beat_valid_i) begin
          beat_d = beat_q + 1'b1;
          if (w_beat_last) begin
            state_d = DONE;
          end
        end else if (w_timeout) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        beat_d  = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    w_xfer      = (state_q == WAIT_RDY) || (state_q == BEAT);
    gnt0_o      = (state_q != IDLE) && (port_q == 1'b0);
    gnt1_o      = (state_q != IDLE) && (port_q == 1'b1);
    done0_o     = (state_q == DONE) && (port_q == 1'b0);
    done1_o     = (state_q == DONE) && (port_q == 1'b1);
    err_o       = (state_q == DONE) && err_q;
    beat_idx_o  = beat_q;
    mem_valid_o = w_xfer;
    mem_load_o  = w_xfer && !we_q;
    mem_store_o = w_xfer && we_q;
    mem_addr_o  = w_xfer ? addr_q : '0;
    mem_wdata_o = w_xfer ? (port_q ? wdata1_i : wdata0_i) : '0;
    rvalid_o    = (state_q == BEAT) && mem_beat_valid_i && !we_q;
  end

  assign rdata_o = mem_rdata_i;

endmodule

`default_nettype wire

// File: doc/mem_block_arbiter.md
Name: mem_block_arbiter

Overview:
- Sequences block (cache-line) transfers to Main_Memory and shares its port between two L1 requesters: port 0 is the I-cache, port 1 is the D-cache.
- Each granted request is one full block: a load (WORDS_PER_BLOCK beats read) or a store (WORDS_PER_BLOCK beats written), followed by a one-cycle DONE.
- Sits between the two L1 controllers and the memory; ties between requesters are resolved round-robin.

Parameters:
- WORDS_PER_BLOCK, 8, 32-bit words per block; power of two, at least 2.
- BEAT_W, 3, beat counter width; equals log2(WORDS_PER_BLOCK).
- TIMEOUT_CYCLES, 64, stall limit; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- CLK  in  1  clock; all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ0 / REQ1  in  1  block request from port 0 / port 1; held until that port's DONE.
- WE0 / WE1  in  1  1 = store, 0 = load; stable while REQ is high.
- ADDR0 / ADDR1  in  32  byte address; any byte within the block.
- WDATA0 / WDATA1  in  32  store data for the word selected by BEAT_IDX.
- GNT0 / GNT1  out  1  high from the grant cycle through the DONE cycle.
- DONE0 / DONE1  out  1  one-cycle pulse when the transfer ends.
- BEAT_IDX  out  BEAT_W  current beat number, 0 to WORDS_PER_BLOCK-1.
- RDATA  out  32  load data; combinational copy of MEM_RDATA.
- RVALID  out  1  RDATA valid; asserted only to the granted port's transfer.
- MEM_VALID  out  1  transaction active toward memory.
- MEM_LOAD / MEM_STORE  out  1  transaction type; one-hot while MEM_VALID is high, both 0 otherwise.
- MEM_ADDR  out  32  block-aligned base address.
- MEM_WDATA  out  32  granted port's WDATA, passed through.
- MEM_READY  in  1  memory accepted the transaction.
- MEM_BEAT_VALID  in  1  one beat completes this cycle (load: MEM_RDATA valid; store: MEM_WDATA consumed).
- MEM_RDATA  in  32  load beat data.
- ERR  out  1  abort flag, pulsed with DONE; tied 0 when the macro is off.

Behaviour:
- Reset values: every output 0; state IDLE; beat counter 0; LAST pointer = 1, so port 0 wins the first tie.
- IDLE:
  - One requester high: grant it.
  - Both high: grant the port that is not LAST.
  - In the grant cycle, register the grant, WE and ADDR; set LAST to the granted port; go to WAIT_RDY.
  - GNTx rises in the first cycle of WAIT_RDY.
- Address rule: MEM_ADDR = ADDR with bits [BEAT_W+1:0] cleared. Example: 0x0000_0047 gives 0x0000_0040.
- WAIT_RDY:
  - Drive MEM_VALID = 1, MEM_LOAD = !WE, MEM_STORE = WE.
  - On MEM_READY = 1, go to BEAT; the counter is already 0.
- BEAT:
  - MEM_VALID and the type signals stay high.
  - Each cycle with MEM_BEAT_VALID = 1, the counter increments. For a load, RVALID = 1 in that same cycle.
  - MEM_BEAT_VALID while in WAIT_RDY or IDLE is ignored.
  - When the beat with index WORDS_PER_BLOCK-1 completes, go to DONE.
- DONE:
  - DONEx = 1 and GNTx = 1 for exactly one cycle; MEM_VALID = 0; counter cleared; next state IDLE.
  - Minimum gap between two transfers is one IDLE cycle.
- Minimum latency: 8-beat load with MEM_READY and every beat back-to-back is 1 (grant) + 1 (WAIT_RDY) + 8 + 1 (DONE) = 11 cycles.
- Requester misbehaviour:
  - REQ dropped mid-transfer is ignored; the transfer completes.
  - The ungranted port's REQ is held off and not lost.
  - A new REQ arriving in the DONE cycle is evaluated in the next IDLE.
- RST asserted mid-transfer: immediate return to IDLE with all outputs 0. No DONE, and no partial-write cleanup.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A stall counter clears on entry to WAIT_RDY and on every completed beat, and increments on every other cycle in WAIT_RDY or BEAT.
  - At TIMEOUT_CYCLES the block goes to DONE with ERR = 1 alongside DONEx.
- Not defined: no counter; the block waits indefinitely and ERR is constant 0.

Decomposition:
- Shared package mem_pkg holds:
  - Constants WORD_W = 32, WORDS_PER_BLOCK, BEAT_W, BLOCK_OFFSET_W = BEAT_W + 2.
  - Typedef arb_state_t {IDLE, WAIT_RDY, BEAT, DONE}.
  - Typedef port_id_t (1 bit).
- One natural sub-module, rr_arbiter2: a two-input round-robin grant with the LAST pointer, reusable elsewhere.
- The FSM, beat counter and timeout counter stay in mem_block_arbiter.

Test Plan:
- Single load: REQ0 = 1, WE0 = 0, ADDR0 = 0x47, memory MEM_READY after 2 cycles, beats back-to-back -> MEM_ADDR = 0x40 and MEM_LOAD = 1; 8 RVALID pulses with BEAT_IDX 0..7 carrying data 0x100..0x107; DONE0 one cycle after beat 7.
- Single store: REQ1 = 1, WE1 = 1, ADDR1 = 0x2C, WDATA1 = 0xA0 + BEAT_IDX, one beat every other cycle -> MEM_STORE = 1, MEM_ADDR = 0x20, MEM_WDATA sequence 0xA0..0xA7, DONE1 pulse, RVALID never set.
- Tie: REQ0 and REQ1 both rise in the same cycle right after reset -> port 0 served first, then port 1 after one IDLE cycle; a second simultaneous tie grants port 1 first.
- Mid-transfer request and drop: REQ1 rises during port 0's beat 3, and REQ0 drops at beat 5 -> port 0 still completes all 8 beats and DONE0; GNT1 begins after the following IDLE cycle.
- Reset mid-transfer: assert RST during beat 4 -> all outputs 0 asynchronously, no DONE; after release, a new REQ0 transfer runs with BEAT_IDX starting at 0.
- Timeout (macro on, TIMEOUT_CYCLES = 16): MEM_READY never asserted -> DONE0 = 1 and ERR = 1 exactly 16 cycles after WAIT_RDY entry; with the macro off the block stays in WAIT_RDY.
